// File: rtl/decoder_pipe_if.sv
// decoder_pipe_if: handshake bundle between a code producer and the decoder_pipe block.
//
// Signals (directions seen from the slave, i.e. the decoder):
//   mode       in   2      00 DECODE, 01 THERMO, 10 SCAN, 11 OFF
//   in_valid   in   1      in_code is valid
//   in_ready   out  1      decoder accepts in_code this cycle
//   in_code    in   IN_W   binary code
//   out_valid  out  1      out_lines holds an unconsumed item
//   out_ready  in   1      downstream consumes the item this cycle
//   out_lines  out  OUT_W  registered decoded lines
//   scan_wrap  out  1      pulse: the scan item just shown is bit OUT_W-1
interface decoder_pipe_if #(
    parameter int IN_W = 3
);
    localparam int OUT_W = 2 ** IN_W;

    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_lines;
    logic             scan_wrap;

    modport master (
        output mode, in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_lines, scan_wrap
    );

    modport slave (
        input  mode, in_valid, in_code, out_ready,
        output in_ready, out_valid, out_lines, scan_wrap
    );
endinterface

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered binary-to-2**IN_W-line decoder (one-hot, thermometer, walking-one scan) with valid/ready on both sides.
//
// Parameters:
//   IN_W      input code width (1..6)
//   SCAN_DIV  clock cycles per scan step (>= 1)
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     decoder_pipe_if slave modport carrying mode, input and output handshakes
module decoder_pipe #(
    parameter int IN_W     = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic          clk,
    input  logic          resetn,
    decoder_pipe_if.slave bus
);
    localparam int OUT_W = 2 ** IN_W;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [1:0] M_DEC    = 2'b00;
    localparam logic [1:0] M_THERMO = 2'b01;
    localparam logic [1:0] M_SCAN   = 2'b10;

    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q, div_d, div_e;
    logic [IN_W-1:0]  idx_q, idx_d, idx_e;
    logic [OUT_W-1:0] lines_q, lines_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic             free, chg, accept, tc, scan_load, in_ready;
    logic [OUT_W-1:0] onehot, therm;

    // State register: mode history, scan divider/index and the output stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q  <= 2'b00;
            div_q   <= '0;
            idx_q   <= '0;
            lines_q <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= bus.mode;
            div_q   <= div_d;
            idx_q   <= idx_d;
            lines_q <= lines_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    // A mode change restarts the scan in the very cycle it is seen, so the
    // change cycle already counts as divider step 0; this puts the first scan
    // item SCAN_DIV cycles after entry and gives one item per cycle at SCAN_DIV=1.
    assign free      = !valid_q || bus.out_ready;
    assign chg       = bus.mode != mode_q;
    assign div_e     = chg ? '0 : div_q;
    assign idx_e     = chg ? '0 : idx_q;
    assign accept    = bus.in_valid && in_ready;
    assign tc        = div_e == DIV_W'(SCAN_DIV - 1);
    assign scan_load = (bus.mode == M_SCAN) && tc && free;

    always_comb begin
        onehot = OUT_W'(1) << bus.in_code;
        for (int i = 0; i < OUT_W; i++) therm[i] = i <= int'(bus.in_code);
    end

    // Next-state logic. At terminal count with a busy stage the divider simply
    // holds, so the pending step is loaded the first cycle the stage frees up.
    always_comb begin
        div_d   = div_e;
        idx_d   = idx_e;
        lines_d = lines_q;
        valid_d = valid_q && !bus.out_ready;
        wrap_d  = 1'b0;
        if (bus.mode == M_SCAN) begin
            div_d = tc ? (free ? '0 : div_e) : div_e + 1'b1;
            idx_d = scan_load ? idx_e + 1'b1 : idx_e;
        end
        if (scan_load) begin
            lines_d = OUT_W'(1) << idx_e;
            valid_d = 1'b1;
            wrap_d  = &idx_e;
        end else if (accept) begin
            lines_d = (bus.mode == M_THERMO) ? therm : onehot;
            valid_d = 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        in_ready      = ((bus.mode == M_DEC) || (bus.mode == M_THERMO)) && free;
        bus.in_ready  = in_ready;
        bus.out_valid = valid_q;
        bus.out_lines = lines_q;
        bus.scan_wrap = wrap_q;
    end
endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: scoreboard bench for decoder_pipe (IN_W=3, SCAN_DIV=4) with directed and random stimulus.
module tb_decoder_pipe;
    localparam int IN_W     = 3;
    localparam int SCAN_DIV = 4;
    localparam int OUT_W    = 2 ** IN_W;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    decoder_pipe_if #(.IN_W(IN_W)) bus ();

    decoder_pipe #(.IN_W(IN_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: items are pushed when the model predicts a load.
    int exp_q[$];
    bit pend;
    bit exp_wrap;
    int prev_mode;
    int waited;
    int nidx;

    // Behavioural model: evaluated mid-cycle, predicting the upcoming edge.
    always @(negedge clk) begin
        bit free;
        bit load;
        int val;
        if (!resetn) begin
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_out_lines", int'(bus.out_lines), 0);
            chk("rst_scan_wrap", int'(bus.scan_wrap), 0);
            exp_q.delete();
            pend = 0;
            exp_wrap = 0;
            prev_mode = 0;
            waited = 0;
            nidx = 0;
        end else begin
            chk("out_valid", int'(bus.out_valid), int'(pend));
            chk("scan_wrap", int'(bus.scan_wrap), int'(exp_wrap));
            free = !pend || bus.out_ready;
            load = 0;
            val = 0;
            exp_wrap = 0;
            if (int'(bus.mode) != prev_mode) begin
                waited = 0;
                nidx = 0;
            end
            if (bus.mode < 2) begin
                chk("in_ready", int'(bus.in_ready), int'(free));
                if (bus.in_valid && free) begin
                    load = 1;
                    val = (bus.mode == 0) ? (1 << bus.in_code) : ((1 << (int'(bus.in_code) + 1)) - 1);
                end
            end else begin
                chk("in_ready_idle", int'(bus.in_ready), 0);
            end
            if (bus.mode == 2) begin
                if (waited < SCAN_DIV) waited++;
                if (waited == SCAN_DIV && free) begin
                    load = 1;
                    val = 1 << nidx;
                    exp_wrap = (nidx == OUT_W - 1);
                    nidx = (nidx + 1) % OUT_W;
                    waited = 0;
                end
            end
            if (load) begin
                exp_q.push_back(val);
                pend = 1;
            end else if (bus.out_ready) begin
                pend = 0;
            end
            prev_mode = int'(bus.mode);
        end
    end

    // Monitor: every handshake on the output side retires one expected item.
    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL item: got %0h expected none at %0t", bus.out_lines, $time);
            end else begin
                chk("item", int'(bus.out_lines), exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic [1:0] m, input logic v, input logic [2:0] c, input logic r);
        bus.mode      = m;
        bus.in_valid  = v;
        bus.in_code   = c;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] m;
        resetn = 1'b0;
        repeat (3) cyc(2'b00, 1'b0, 3'd0, 1'b1);
        resetn = 1'b1;
        cyc(2'b00, 1'b1, 3'd5, 1'b1);
        for (int i = 0; i < 8; i++) cyc(2'b00, 1'b1, 3'(i), 1'b1);
        cyc(2'b11, 1'b0, 3'd0, 1'b1);
        cyc(2'b01, 1'b1, 3'd0, 1'b1);
        cyc(2'b01, 1'b1, 3'd3, 1'b1);
        cyc(2'b01, 1'b1, 3'd7, 1'b1);
        cyc(2'b11, 1'b0, 3'd0, 1'b1);
        cyc(2'b00, 1'b1, 3'd2, 1'b0);
        repeat (4) cyc(2'b00, 1'b1, 3'd6, 1'b0);
        cyc(2'b00, 1'b1, 3'd6, 1'b1);
        cyc(2'b11, 1'b0, 3'd0, 1'b1);
        repeat (40) cyc(2'b10, 1'b0, 3'd0, 1'b1);
        cyc(2'b11, 1'b0, 3'd0, 1'b1);
        repeat (12) cyc(2'b10, 1'b0, 3'd0, 1'b1);
        repeat (10) cyc(2'b10, 1'b0, 3'd0, 1'b0);
        repeat (20) cyc(2'b10, 1'b0, 3'd0, 1'b1);
        repeat (3) cyc(2'b00, 1'b1, 3'($urandom_range(0, 7)), 1'b1);
        repeat (12) cyc(2'b10, 1'b0, 3'd0, 1'b1);
        cyc(2'b00, 1'b1, 3'd4, 1'b0);
        resetn = 1'b0;
        cyc(2'b00, 1'b0, 3'd0, 1'b1);
        resetn = 1'b1;
        repeat (10) cyc(2'b10, 1'b0, 3'd0, 1'b1);
        m = 2'b00;
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) resetn = 1'b0;
            cyc(m, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
            resetn = 1'b1;
        end
        repeat (3) cyc(2'b11, 1'b0, 3'd0, 1'b1);
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, registered binary-to-N-line decoder with valid/ready handshakes on both sides. It offers one-hot decoding, thermometer decoding and a self-timed walking-one scan mode. It is the sequential successor of the combinational 3-to-8 decoder and drives select/enable lines in streaming datapaths where backpressure must be honoured.

## Interface
Parameters:
- IN_W, default 3: input code width, legal range 1..6.
- SCAN_DIV, default 4: clock cycles per scan step, must be ≥ 1.
- OUT_W, derived as 2**IN_W (localparam, not overridable): output line count.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- mode  input  2  operating mode:
  - 00: DECODE, one-hot.
  - 01: THERMO, thermometer.
  - 10: SCAN, walking one.
  - 11: OFF.
- in_valid  input  1  in_code is valid.
- in_ready  output  1  block accepts in_code this cycle.
- in_code  input  IN_W  binary code.
- out_valid  output  1  out_lines holds an unconsumed item.
- out_ready  input  1  downstream consumes the item this cycle.
- out_lines  output  OUT_W  registered decoded lines.
- scan_wrap  output  1  one-cycle pulse; the scan item just loaded was bit OUT_W-1.

## Operation
- Output stage: a single register holding out_lines and out_valid. It is free when out_valid=0 or out_ready=1.
- in_ready is combinational: (mode==00 or mode==01) and stage free.
- Accept: in_valid and in_ready.
  - DECODE loads out_lines = 1 << in_code.
  - THERMO loads out_lines bits [in_code:0] = 1 and all others 0.
  - out_valid is set to 1 on accept.
- Consume without a new load: out_valid and out_ready with no accept and no scan load. out_valid clears to 0; out_lines holds its last value.
- Simultaneous consume and load: the new item replaces the old one and out_valid stays 1. This gives full throughput of one item per cycle.
- SCAN mode:
  - Inputs are ignored and in_ready is 0.
  - A divider counts 0..SCAN_DIV-1.
  - At terminal count with the stage free, the block loads out_lines = 1 << idx and sets out_valid=1. idx then increments, wrapping from OUT_W-1 to 0, and the divider returns to 0.
  - At terminal count with the stage not free, the divider holds at terminal count (stall). The load happens in the first cycle the stage is free. No step is skipped or duplicated.
  - scan_wrap is registered and high in the same cycle that out_lines first shows bit OUT_W-1 set.
- OFF mode: no new items. A pending item remains and can still be consumed normally.
- Mode change:
  - Any cycle where mode differs from its registered previous value resets the divider and idx to 0.
  - A mode change never flushes or alters a pending output item.
- State machine: mode register plus divider (width ≥ clog2(SCAN_DIV)) and idx (IN_W bits). There are no other hidden states.

## Timing
- Reset (resetn=0, asynchronous) sets:
  - out_lines = 0, out_valid = 0, scan_wrap = 0.
  - idx = 0, divider = 0, previous mode = 00.
- After reset, in_ready follows its combinational rule immediately.
- DECODE/THERMO latency: accept in cycle N gives out_valid=1 with the decoded value in cycle N+1.
- SCAN, first item:
  - Enter SCAN in cycle N, where mode is first seen as 10.
  - The first item (bit 0) appears at cycle N+SCAN_DIV, provided there is no stall.
  - Subsequent items appear every SCAN_DIV cycles while out_ready is held at 1.
- SCAN_DIV=1: one scan item per cycle.
- Reset asserted mid-operation: all state clears in the same cycle. Any pending item is lost.
- in_code is sampled only on the accepting edge. Its value is don't-care otherwise.

## Test plan
- Reset, then DECODE with IN_W=3, in_code=5 and out_ready=1 -> next cycle out_lines=8'b0010_0000 and out_valid=1. Back-to-back codes 0..7 -> eight outputs in consecutive cycles.
- THERMO with in_code=0, 3, 7 -> out_lines = 8'b0000_0001, 8'b0000_1111, 8'b1111_1111.
- Backpressure: out_ready=0 with one item pending -> in_ready=0, the held item is unchanged, and in_valid is not accepted. Then set out_ready=1 with a new code -> the old item is consumed and the new item is loaded in the same cycle.
- SCAN with SCAN_DIV=4 and out_ready=1 -> items 0x01, 0x02, …, 0x80 every 4 cycles, the first at entry+4. scan_wrap pulses once, with 0x80. The next item after that is 0x01.
- SCAN stall: hold out_ready=0 for 10 cycles after the item 0x04 -> the next item is 0x08 (no skip), loaded the cycle after out_ready returns to 1.
- Switch SCAN→DECODE→SCAN mid-sequence, and assert resetn=0 while out_valid=1 -> the scan restarts at 0x01 after re-entry. Reset clears out_valid, out_lines and scan_wrap in the same cycle.
